// File: rtl/lcd_rx_pkg.sv
// rtl/lcd_rx_pkg.sv - shared types and panel defaults for the RGB565 capture path
//
// Purpose: capture FSM state encoding, default panel geometry and pixel width.
// Ports:   none (package).
package lcd_rx_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } lcd_rx_state_t;

  localparam int H_ACTIVE_480 = 480;
  localparam int V_ACTIVE_272 = 272;
  localparam int RGB_W        = 16;

endpackage

// File: rtl/lcd_sync_edge.sv
// rtl/lcd_sync_edge.sv - input register stage and vsync/DE falling-edge detectors
//
// Purpose: registers the panel timing inputs once and flags the falling edges
//          of the registered vsync and data enable.
// Ports:
//   i_clk, i_rst          pixel clock, asynchronous active-high reset
//   i_vs, i_hs, i_de      raw vsync (low), hsync (low), data enable (high)
//   i_rgb                 raw RGB565 pixel
//   o_hs, o_de, o_rgb     registered hsync, data enable and pixel
//   o_vs_fall, o_de_fall  one-cycle falling-edge flags of registered vs / de
module lcd_sync_edge
  import lcd_rx_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_vs,
  input  logic             i_hs,
  input  logic             i_de,
  input  logic [RGB_W-1:0] i_rgb,
  output logic             o_hs,
  output logic             o_de,
  output logic [RGB_W-1:0] o_rgb,
  output logic             o_vs_fall,
  output logic             o_de_fall
);

  logic             r_vs;
  logic             r_vs_d;
  logic             r_hs;
  logic             r_de;
  logic             r_de_d;
  logic [RGB_W-1:0] r_rgb;

  // Sync history resets low so a vsync already low at reset release is not
  // mistaken for a falling edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vs   <= 1'b0;
      r_vs_d <= 1'b0;
      r_hs   <= 1'b0;
      r_de   <= 1'b0;
      r_de_d <= 1'b0;
      r_rgb  <= '0;
    end else begin
      r_vs   <= i_vs;
      r_vs_d <= r_vs;
      r_hs   <= i_hs;
      r_de   <= i_de;
      r_de_d <= r_de;
      r_rgb  <= i_rgb;
    end
  end

  assign o_hs      = r_hs;
  assign o_de      = r_de;
  assign o_rgb     = r_rgb;
  assign o_vs_fall = r_vs_d & ~r_vs;
  assign o_de_fall = r_de_d & ~r_de;

endmodule

// File: rtl/lcd_rgb_rx.sv
// rtl/lcd_rgb_rx.sv - parallel RGB565 capture into a downstream write FIFO
//
// Purpose: recovers frame/line boundaries from vsync/DE, writes active pixels
//          to a FIFO and reports position, measured line length and errors.
// Ports:
//   lcd_clk, sys_rst                 pixel clock, asynchronous active-high reset
//   lcd_vs, lcd_hs, lcd_de, lcd_rgb  panel timing and RGB565 data
//   cap_en                           capture arm (level)
//   err_clr                          clears sticky error flags (set wins)
//   fifo_full                        downstream FIFO full
//   fifo_wr_req, fifo_wr_data        pixel write strobe and data
//   frame_start, frame_done          one-cycle frame pulses
//   capturing                        high while in CAPTURE
//   pixel_xpos, pixel_ypos           current pixel / line index
//   line_len                         DE-high count of last completed line
//   err_line, err_ovf, err_frame     sticky line-length / overflow / early-vsync
module lcd_rgb_rx
  import lcd_rx_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_480,
  parameter int V_ACTIVE = V_ACTIVE_272,
  parameter int XW       = 10
) (
  input  logic             lcd_clk,
  input  logic             sys_rst,
  input  logic             lcd_vs,
  input  logic             lcd_hs,
  input  logic             lcd_de,
  input  logic [RGB_W-1:0] lcd_rgb,
  input  logic             cap_en,
  input  logic             err_clr,
  input  logic             fifo_full,
  output logic             fifo_wr_req,
  output logic [RGB_W-1:0] fifo_wr_data,
  output logic             frame_start,
  output logic             frame_done,
  output logic             capturing,
  output logic [XW-1:0]    pixel_xpos,
  output logic [XW-1:0]    pixel_ypos,
  output logic [XW-1:0]    line_len,
  output logic             err_line,
  output logic             err_ovf,
  output logic             err_frame
);

  localparam logic [XW-1:0] H_LEN  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] V_LAST = XW'(V_ACTIVE - 1);
  localparam logic [XW-1:0] X_SAT  = '1;

  lcd_rx_state_t r_state;
  lcd_rx_state_t w_state_nxt;

  logic             w_hs_q;
  logic             w_de_q;
  logic [RGB_W-1:0] w_rgb_q;
  logic             w_vs_fall;
  logic             w_de_fall;

  logic             r_wr_req;
  logic [RGB_W-1:0] r_wr_data;
  logic             r_frame_start;
  logic [XW-1:0]    r_xpos;
  logic [XW-1:0]    r_ypos;
  logic [XW-1:0]    r_line_len;
  logic             r_err_line;
  logic             r_err_ovf;
  logic             r_err_frame;

  logic w_frame_begin;
  logic w_frame_abort;
  logic w_line_end;
  logic w_pix;
  logic w_pix_keep;
  logic w_wr;
  logic w_unused_hs;

  lcd_sync_edge u_sync_edge (
    .i_clk     (lcd_clk),
    .i_rst     (sys_rst),
    .i_vs      (lcd_vs),
    .i_hs      (lcd_hs),
    .i_de      (lcd_de),
    .i_rgb     (lcd_rgb),
    .o_hs      (w_hs_q),
    .o_de      (w_de_q),
    .o_rgb     (w_rgb_q),
    .o_vs_fall (w_vs_fall),
    .o_de_fall (w_de_fall)
  );

  // hsync is sampled for completeness only; framing relies on DE.
  assign w_unused_hs = w_hs_q;

  always_ff @(posedge lcd_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_frame_begin = 1'b0;
    w_frame_abort = 1'b0;
    w_line_end    = 1'b0;
    case (r_state)
      IDLE: begin
        if (cap_en) w_state_nxt = WAIT_VS;
      end
      WAIT_VS: begin
        if (!cap_en) begin
          w_state_nxt = IDLE;
        end else if (w_vs_fall) begin
          w_state_nxt   = CAPTURE;
          w_frame_begin = 1'b1;
        end
      end
      CAPTURE: begin
        // Completing the last line takes precedence over a coincident vsync,
        // so a full frame is never reported as aborted.
        if (w_de_fall && (r_ypos == V_LAST)) begin
          w_line_end  = 1'b1;
          w_state_nxt = DONE;
        end else if (w_vs_fall) begin
          w_frame_begin = 1'b1;
          w_frame_abort = 1'b1;
        end else if (w_de_fall) begin
          w_line_end = 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = cap_en ? WAIT_VS : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Registered DE implies no DE falling edge in the same cycle, so pixel and
  // line-end handling never overlap.
  assign w_pix      = (r_state == CAPTURE) && w_de_q && !w_frame_abort;
  assign w_pix_keep = w_pix && (r_xpos < H_LEN);
  assign w_wr       = w_pix_keep && !fifo_full;

  always_ff @(posedge lcd_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_wr_req      <= 1'b0;
      r_wr_data     <= '0;
      r_frame_start <= 1'b0;
      r_xpos        <= '0;
      r_ypos        <= '0;
      r_line_len    <= '0;
      r_err_line    <= 1'b0;
      r_err_ovf     <= 1'b0;
      r_err_frame   <= 1'b0;
    end else begin
      r_wr_req      <= w_wr;
      r_frame_start <= w_frame_begin;
      if (w_wr) r_wr_data <= w_rgb_q;

      if (w_frame_begin) begin
        r_xpos <= '0;
        r_ypos <= '0;
      end else if (w_line_end) begin
        r_line_len <= r_xpos;
        r_xpos     <= '0;
        r_ypos     <= r_ypos + 1'b1;
      end else if (w_pix && (r_xpos != X_SAT)) begin
        r_xpos <= r_xpos + 1'b1;
      end

      // Set has priority over a simultaneous clear.
      r_err_line  <= (r_err_line  & ~err_clr) | (w_line_end && (r_xpos != H_LEN));
      r_err_ovf   <= (r_err_ovf   & ~err_clr) | (w_pix && fifo_full);
      r_err_frame <= (r_err_frame & ~err_clr) | w_frame_abort;
    end
  end

  assign fifo_wr_req  = r_wr_req;
  assign fifo_wr_data = r_wr_data;
  assign frame_start  = r_frame_start;
  assign frame_done   = (r_state == DONE);
  assign capturing    = (r_state == CAPTURE);
  assign pixel_xpos   = r_xpos;
  assign pixel_ypos   = r_ypos;
  assign line_len     = r_line_len;
  assign err_line     = r_err_line;
  assign err_ovf      = r_err_ovf;
  assign err_frame    = r_err_frame;

endmodule
